// File: rtl/reset_pkg.sv
// Shared types for the reset sequencer: FSM states and reset-cause encodings.
package reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

endpackage

// File: rtl/reset_sync.sv
// Three-flop reset synchroniser: asserts asynchronously, deasserts on the third clk edge.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic o_rst
);

  logic [2:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_chain <= '0;
    else        r_chain <= {r_chain[1:0], 1'b1};
  end

  assign o_rst = ~r_chain[2];

endmodule

// File: rtl/reset_sequencer.sv
// System reset controller: synchronises nreset, qualifies with PLL lock and releases
// the domain resets one at a time, re-sequencing on PLL loss, software or watchdog request.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 pll_locked,
  input  logic                 sw_reset_req,
  input  logic                 wdt_reset_req,
  output logic [N_DOMAINS-1:0] reset_out,
  output logic                 seq_done,
  output logic [1:0]           reset_cause
);

  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOMAINS - 1);

  logic                 w_rst_i;
  logic                 r_pll_meta;
  logic                 r_pll_sync;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [N_DOMAINS-1:0] r_reset_out;
  logic                 r_seq_done;
  logic [1:0]           r_cause;

  logic                 w_pll_fall;
  logic                 w_abort;
  logic [1:0]           w_abort_cause;
  logic [N_DOMAINS-1:0] w_next_mask;

  reset_sync u_reset_sync (
    .clk   (clk),
    .rst_n (nreset),
    .o_rst (w_rst_i)
  );

  always_ff @(posedge clk or posedge w_rst_i) begin
    if (w_rst_i) begin
      r_pll_meta <= 1'b0;
      r_pll_sync <= 1'b0;
    end else begin
      r_pll_meta <= pll_locked;
      r_pll_sync <= r_pll_meta;
    end
  end

  // The falling edge is seen on the same clk edge that pll_sync itself drops.
  assign w_pll_fall = r_pll_sync & ~r_pll_meta;
  assign w_abort    = wdt_reset_req | sw_reset_req | w_pll_fall;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_abort_cause = CAUSE_PLL;
    if (wdt_reset_req)     w_abort_cause = CAUSE_WDT;
    else if (sw_reset_req) w_abort_cause = CAUSE_SW;
  end

  always_comb begin
    w_next_mask = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (i == int'(r_idx) + 1) w_next_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge w_rst_i) begin
    if (w_rst_i) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_reset_out <= '1;
      r_seq_done  <= 1'b0;
      r_cause     <= CAUSE_POR;
    end else if (w_abort) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_reset_out <= '1;
      r_seq_done  <= 1'b0;
      r_cause     <= w_abort_cause;
    end else begin
      case (r_state)
        HOLD: begin
          if (!r_pll_sync) begin
            r_cnt <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state        <= RELEASE;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_reset_out[0] <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (r_cnt == STAGE_LAST) begin
            r_cnt <= '0;
            if (r_idx != IDX_LAST) begin
              r_idx       <= r_idx + 1'b1;
              r_reset_out <= r_reset_out & ~w_next_mask;
            end else begin
              r_state    <= RUN;
              r_seq_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN:     ;
        default: r_state <= HOLD;
      endcase
    end
  end

  assign reset_out   = r_reset_out;
  assign seq_done    = r_seq_done;
  assign reset_cause = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (N_DOMAINS=3, HOLD_CYCLES=4, STAGE_DELAY=2).
// Observed vector is {reset_out, seq_done, reset_cause}; edge numbers are hand-derived.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       wdt_reset_req = 1'b0;
  logic [2:0] reset_out;
  logic       seq_done;
  logic [1:0] reset_cause;
  logic [5:0] obs;

  int passed = 0;
  int total  = 0;

  reset_sequencer #(
    .N_DOMAINS   (3),
    .HOLD_CYCLES (4),
    .STAGE_DELAY (2),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .pll_locked    (pll_locked),
    .sw_reset_req  (sw_reset_req),
    .wdt_reset_req (wdt_reset_req),
    .reset_out     (reset_out),
    .seq_done      (seq_done),
    .reset_cause   (reset_cause)
  );

  always #5 clk = ~clk;

  assign obs = {reset_out, seq_done, reset_cause};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got time %0t, required < 100000", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Deassert nreset mid-cycle; the next posedge is edge 1.
  task automatic release_nreset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; pll_locked = 1'b1;
    #23;
    total++;
    if (obs !== 6'b111_0_00) $display("FAIL reset_state: got %b, required %b", obs, 6'b111_0_00);
    else passed++;
  endtask

  task automatic test_por();
    release_nreset();
    step(8);
    total++;
    if (obs !== 6'b111_0_00) $display("FAIL por_edge8: got %b, required %b", obs, 6'b111_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b110_0_00) $display("FAIL por_edge9: got %b, required %b", obs, 6'b110_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b110_0_00) $display("FAIL por_edge10: got %b, required %b", obs, 6'b110_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b100_0_00) $display("FAIL por_edge11: got %b, required %b", obs, 6'b100_0_00);
    else passed++;
    step(2);
    total++;
    if (obs !== 6'b000_0_00) $display("FAIL por_edge13: got %b, required %b", obs, 6'b000_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b000_0_00) $display("FAIL por_edge14: got %b, required %b", obs, 6'b000_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b000_1_00) $display("FAIL por_edge15: got %b, required %b", obs, 6'b000_1_00);
    else passed++;
  endtask

  task automatic test_pll_late();
    nreset = 1'b0; pll_locked = 1'b0;
    #17;
    release_nreset();
    step(20);
    total++;
    if (obs !== 6'b111_0_00) $display("FAIL pll_late_edge20: got %b, required %b", obs, 6'b111_0_00);
    else passed++;
    pll_locked = 1'b1;
    step(5);
    total++;
    if (obs !== 6'b111_0_00) $display("FAIL pll_late_edge25: got %b, required %b", obs, 6'b111_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b110_0_00) $display("FAIL pll_late_edge26: got %b, required %b", obs, 6'b110_0_00);
    else passed++;
    step(6);
    total++;
    if (obs !== 6'b000_1_00) $display("FAIL pll_late_run: got %b, required %b", obs, 6'b000_1_00);
    else passed++;
  endtask

  task automatic test_sw_in_run();
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    total++;
    if (obs !== 6'b111_0_10) $display("FAIL sw_abort: got %b, required %b", obs, 6'b111_0_10);
    else passed++;
    step(3);
    total++;
    if (obs !== 6'b111_0_10) $display("FAIL sw_hold: got %b, required %b", obs, 6'b111_0_10);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b110_0_10) $display("FAIL sw_release0: got %b, required %b", obs, 6'b110_0_10);
    else passed++;
    step(6);
    total++;
    if (obs !== 6'b000_1_10) $display("FAIL sw_run: got %b, required %b", obs, 6'b000_1_10);
    else passed++;
  endtask

  task automatic test_back_to_back();
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    step(6);
    total++;
    if (obs !== 6'b100_0_10) $display("FAIL b2b_idx1: got %b, required %b", obs, 6'b100_0_10);
    else passed++;
    sw_reset_req = 1'b1; wdt_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0; wdt_reset_req = 1'b0;
    total++;
    if (obs !== 6'b111_0_11) $display("FAIL b2b_wdt_wins: got %b, required %b", obs, 6'b111_0_11);
    else passed++;
    step(4);
    total++;
    if (obs !== 6'b110_0_11) $display("FAIL b2b_release0: got %b, required %b", obs, 6'b110_0_11);
    else passed++;
    step(6);
    total++;
    if (obs !== 6'b000_1_11) $display("FAIL b2b_run: got %b, required %b", obs, 6'b000_1_11);
    else passed++;
  endtask

  task automatic test_pll_loss();
    pll_locked = 1'b0;
    step(1);
    total++;
    if (obs !== 6'b000_1_11) $display("FAIL pll_loss_edge1: got %b, required %b", obs, 6'b000_1_11);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b111_0_01) $display("FAIL pll_loss_edge2: got %b, required %b", obs, 6'b111_0_01);
    else passed++;
    step(3);
    pll_locked = 1'b1;
    step(5);
    total++;
    if (obs !== 6'b111_0_01) $display("FAIL pll_relock_hold: got %b, required %b", obs, 6'b111_0_01);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b110_0_01) $display("FAIL pll_relock_release: got %b, required %b", obs, 6'b110_0_01);
    else passed++;
  endtask

  task automatic test_nreset_async();
    step(2);
    total++;
    if (obs !== 6'b100_0_01) $display("FAIL async_pre: got %b, required %b", obs, 6'b100_0_01);
    else passed++;
    #3;
    nreset = 1'b0;
    #1;
    total++;
    if (obs !== 6'b111_0_00) $display("FAIL async_immediate: got %b, required %b", obs, 6'b111_0_00);
    else passed++;
    #2;
    nreset = 1'b1;
    step(8);
    total++;
    if (obs !== 6'b111_0_00) $display("FAIL async_edge8: got %b, required %b", obs, 6'b111_0_00);
    else passed++;
    step(1);
    total++;
    if (obs !== 6'b110_0_00) $display("FAIL async_edge9: got %b, required %b", obs, 6'b110_0_00);
    else passed++;
    step(6);
    total++;
    if (obs !== 6'b000_1_00) $display("FAIL async_edge15: got %b, required %b", obs, 6'b000_1_00);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_por();
    test_pll_late();
    test_sw_in_run();
    test_back_to_back();
    test_pll_loss();
    test_nreset_async();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
